// File: rtl/contador_param.sv
// Up/down counter with runtime inclusive limit, programmable step, wrap/saturate
// bound handling, registered terminal-count pulse and sticky overflow flag.
module contador_param #(
    parameter int WIDTH     = 12,
    parameter int STEP_W    = 4,
    parameter int RESET_VAL = 0
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              LOAD,
    input  logic              ENABLE,
    input  logic              UP,
    input  logic              SAT,
    input  logic [STEP_W-1:0] STEP,
    input  logic [WIDTH-1:0]  DLOAD,
    input  logic [WIDTH-1:0]  LIMIT,
    input  logic              CLR_OVF,
    output logic [WIDTH-1:0]  Y,
    output logic              TC,
    output logic              OVF
);

    localparam int XW = WIDTH + 1;
    typedef logic [XW-1:0] ext_t;

    localparam logic [WIDTH-1:0] RST_Y = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] y_q, y_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    ext_t y_ext, lim_ext, step_ext, sum_ext, diff_ext;
    logic bound_evt;

    // Extra top bit keeps the carry of Y+STEP visible, so a full-range
    // counter produces an event rather than silently truncating.
    always_comb begin
        y_ext    = ext_t'(y_q);
        lim_ext  = ext_t'(LIMIT);
        step_ext = ext_t'(STEP);
        sum_ext  = y_ext + step_ext;
        diff_ext = y_ext - step_ext;
    end

    always_comb begin
        y_d       = y_q;
        bound_evt = 1'b0;
        if (LOAD) begin
            y_d = (DLOAD > LIMIT) ? LIMIT : DLOAD;
        end else if (ENABLE && (STEP != '0)) begin
            if (UP) begin
                if (sum_ext <= lim_ext) begin
                    y_d = sum_ext[WIDTH-1:0];
                end else begin
                    bound_evt = 1'b1;
                    y_d       = SAT ? LIMIT : '0;
                end
            end else begin
                // A lowered LIMIT pulls an out-of-range count back into range.
                if (y_q > LIMIT) begin
                    bound_evt = 1'b1;
                    y_d       = LIMIT;
                end else if (y_ext >= step_ext) begin
                    y_d = diff_ext[WIDTH-1:0];
                end else begin
                    bound_evt = 1'b1;
                    y_d       = SAT ? '0 : LIMIT;
                end
            end
        end
    end

    always_comb begin
        tc_d  = bound_evt;
        ovf_d = ovf_q;
        if (CLR_OVF) ovf_d = 1'b0;
        if (bound_evt) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            y_q   <= RST_Y;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign Y   = y_q;
    assign TC  = tc_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_contador_param.sv
// Self-checking bench for contador_param: directed bound scenarios plus
// randomized traffic compared against an integer reference model.
module tb_contador_param;

    localparam int W  = 12;
    localparam int SW = 4;
    localparam int RV = 0;

    logic          clk = 1'b0;
    logic          RESET, LOAD, ENABLE, UP, SAT, CLR_OVF;
    logic [SW-1:0] STEP;
    logic [W-1:0]  DLOAD, LIMIT;
    logic [W-1:0]  Y;
    logic          TC, OVF;

    int n_chk = 0;
    int n_err = 0;
    int m_y, m_tc, m_ovf;

    contador_param #(.WIDTH(W), .STEP_W(SW), .RESET_VAL(RV)) dut (
        .clk(clk), .RESET(RESET), .LOAD(LOAD), .ENABLE(ENABLE), .UP(UP),
        .SAT(SAT), .STEP(STEP), .DLOAD(DLOAD), .LIMIT(LIMIT),
        .CLR_OVF(CLR_OVF), .Y(Y), .TC(TC), .OVF(OVF)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the counting rules.
    task automatic model_edge();
        int lim, y, st, ev;
        lim = int'(LIMIT);
        y   = m_y;
        st  = int'(STEP);
        ev  = 0;
        if (LOAD) begin
            m_y = (int'(DLOAD) < lim) ? int'(DLOAD) : lim;
        end else if (ENABLE && st > 0) begin
            if (UP) begin
                if (y + st <= lim) m_y = y + st;
                else begin ev = 1; m_y = SAT ? lim : 0; end
            end else begin
                if (y > lim) begin ev = 1; m_y = lim; end
                else if (y >= st) m_y = y - st;
                else begin ev = 1; m_y = SAT ? 0 : lim; end
            end
        end
        m_tc = ev;
        if (CLR_OVF) m_ovf = 0;
        if (ev) m_ovf = 1;
    endtask

    task automatic model_reset();
        m_y = RV; m_tc = 0; m_ovf = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".Y"}, 32'(Y), 32'(m_y));
        chk({tag, ".TC"}, 32'(TC), 32'(m_tc));
        chk({tag, ".OVF"}, 32'(OVF), 32'(m_ovf));
    endtask

    task automatic do_load(input int val);
        LOAD = 1'b1; DLOAD = W'(val);
        cyc();
        LOAD = 1'b0;
    endtask

    int exp_y[4];
    int exp_tc[4];

    initial begin
        RESET = 1'b1; LOAD = 0; ENABLE = 0; UP = 1; SAT = 0; CLR_OVF = 0;
        STEP = '0; DLOAD = '0; LIMIT = '0;
        model_reset();
        #12;
        chk("rst.Y", 32'(Y), RV);
        chk("rst.TC", 32'(TC), 0);
        chk("rst.OVF", 32'(OVF), 0);
        @(negedge clk);
        RESET = 1'b0;

        // Free count up to 10
        LIMIT = 12'hFFF; STEP = 1; UP = 1; ENABLE = 1;
        repeat (10) cyc();
        chk("s1.Y", 32'(Y), 10);
        chk("s1.TC", 32'(TC), 0);
        chk("s1.OVF", 32'(OVF), 0);

        // Wrap at LIMIT
        ENABLE = 0; LIMIT = 12'h040; SAT = 0;
        do_load(12'h03C);
        chk("s2.load", 32'(Y), 60);
        ENABLE = 1; STEP = 2;
        exp_y = '{62, 64, 0, 0}; exp_tc = '{0, 0, 1, 0};
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("s2.Y%0d", i), 32'(Y), 32'(exp_y[i]));
            chk($sformatf("s2.TC%0d", i), 32'(TC), 32'(exp_tc[i]));
            check_model("s2.m");
        end
        ENABLE = 0;
        repeat (3) cyc();
        chk("s2.ovf_sticky", 32'(OVF), 1);
        chk("s2.tc_drop", 32'(TC), 0);
        CLR_OVF = 1; cyc(); CLR_OVF = 0;
        chk("s2.ovf_clr", 32'(OVF), 0);

        // Saturate at LIMIT
        SAT = 1;
        do_load(12'h03C);
        ENABLE = 1;
        exp_y = '{62, 64, 64, 64}; exp_tc = '{0, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("s3.Y%0d", i), 32'(Y), 32'(exp_y[i]));
            chk($sformatf("s3.TC%0d", i), 32'(TC), 32'(exp_tc[i]));
        end
        CLR_OVF = 1; cyc();
        chk("s3.set_wins", 32'(OVF), 1);
        chk("s3.tc_pinned", 32'(TC), 1);
        ENABLE = 0; cyc(); CLR_OVF = 0;
        chk("s3.ovf_clr", 32'(OVF), 0);
        check_model("s3.m");

        // Down wrap
        LIMIT = 12'h00A; UP = 0; SAT = 0; STEP = 4;
        do_load(3);
        ENABLE = 1;
        cyc();
        chk("s4.Y0", 32'(Y), 10);
        chk("s4.TC0", 32'(TC), 1);
        cyc();
        chk("s4.Y1", 32'(Y), 6);
        chk("s4.TC1", 32'(TC), 0);
        ENABLE = 0; CLR_OVF = 1; cyc(); CLR_OVF = 0;

        // Load clamp, load priority, zero step
        LIMIT = 12'h050;
        do_load(12'h100);
        chk("s5.clamp", 32'(Y), 12'h050);
        LOAD = 1; ENABLE = 1; UP = 1; STEP = 3; DLOAD = 12'h020;
        cyc(); LOAD = 0;
        chk("s5.load_wins", 32'(Y), 12'h020);
        STEP = 0; cyc();
        chk("s5.step0.Y", 32'(Y), 12'h020);
        chk("s5.step0.TC", 32'(TC), 0);
        check_model("s5.m");

        // Full-range carry, LIMIT=0, lowered LIMIT
        ENABLE = 0; LIMIT = 12'hFFF; SAT = 0;
        do_load(12'hFFF);
        ENABLE = 1; UP = 1; STEP = 1; cyc();
        chk("carry.Y", 32'(Y), 0);
        chk("carry.TC", 32'(TC), 1);
        LIMIT = 0; STEP = 5; cyc();
        chk("lim0.Y", 32'(Y), 0);
        chk("lim0.TC", 32'(TC), 1);
        ENABLE = 0; LIMIT = 12'h040;
        do_load(12'h030);
        LIMIT = 12'h010; UP = 0; STEP = 1; ENABLE = 1; cyc();
        chk("lower.Y", 32'(Y), 12'h010);
        chk("lower.TC", 32'(TC), 1);
        check_model("lower.m");

        // Asynchronous reset mid-count
        LIMIT = 12'hFFF; UP = 1; STEP = 1; SAT = 0;
        repeat (4) cyc();
        #3 RESET = 1'b1;
        #1;
        model_reset();
        chk("s6.Y", 32'(Y), RV);
        chk("s6.TC", 32'(TC), 0);
        chk("s6.OVF", 32'(OVF), 0);
        @(negedge clk);
        RESET = 1'b0;
        repeat (3) begin
            cyc();
            check_model("s6.resume");
        end
        chk("s6.Y3", 32'(Y), RV + 3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            LOAD    = ($urandom_range(0, 15) == 0);
            ENABLE  = ($urandom_range(0, 3) != 0);
            UP      = $urandom_range(0, 1);
            SAT     = $urandom_range(0, 1);
            CLR_OVF = ($urandom_range(0, 9) == 0);
            STEP    = SW'($urandom_range(0, (1 << SW) - 1));
            DLOAD   = W'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                case ($urandom_range(0, 3))
                    0: LIMIT = '0;
                    1: LIMIT = '1;
                    2: LIMIT = W'($urandom_range(1, 20));
                    default: LIMIT = W'($urandom);
                endcase
            end
            cyc();
            check_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
